fp_to_int_pipe: RTL and testbench
=================================

# fp_to_int_pipe

Parametrised, two-stage pipelined floating-point to integer converter for the FPU. Generalises bfloat16 conversion to any EXP_W/MAN_W/INT_W. Classifies its own operand, produces true two's-complement signed or unsigned results with saturation, and supports IEEE rounding modes. Sits between the FPU operand mux and the integer writeback path behind valid/ready handshakes.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 7, stored mantissa width (hidden bit implicit)
- INT_W, 32, result width
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  converter can accept
- fp_i  in  1+EXP_W+MAN_W  {sign, exp, mantissa}
- signed_i  in  1  1: signed result, 0: unsigned
- rnd_mode_i  in  2  00 RNE, 01 RTZ, 10 RDN, 11 RUP
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts
- int_o  out  INT_W  two's-complement result
- flag_o  out  3  [0] invalid/overflow, [1] underflow, [2] inexact

## Operation
- BIAS = 2^(EXP_W-1)-1; E = exp - BIAS.
- exp all ones: mantissa 0 is ±Inf, else NaN. exp 0: ±0 or subnormal; subnormals are flushed to 0.
- Normal: magnitude = 1.mant × 2^E. Integer part and guard/sticky bits are computed by a right shift of INT_W+1 bits. A shift ≥ INT_W+1 gives integer 0 and sticky = 1.
- Rounding follows the selected mode on the sign-magnitude value, before negation. RDN/RUP are sign-aware.
- Range limits after rounding:
  - signed: [-2^(INT_W-1), 2^(INT_W-1)-1]
  - unsigned: [0, 2^INT_W-1]
- Saturation, with flag[0] set:
  - +Inf, NaN, or positive overflow: signed 2^(INT_W-1)-1, unsigned all ones.
  - -Inf or negative overflow: signed -2^(INT_W-1), unsigned 0.
  - unsigned with rounded negative nonzero magnitude: 0.
- flag[1] is set for a subnormal input, or a nonzero normal input whose rounded result is 0.
- flag[2] is set when discarded bits are nonzero. It is cleared whenever flag[0] is set.
- ±0 gives 0 with all flags 0.

## Timing
- Stage 1 registers the classification, sign, shift amount and mode. Stage 2 registers the rounded, negated and saturated result plus flags.
- Latency: a handshake in cycle N gives out_valid_o in cycle N+2 when there is no backpressure. Throughput is 1 per cycle.
- s2 advances when !s2_valid || out_ready_i. s1 advances when s2 can load.
- in_ready_o = !s1_valid || s1 can advance (combinational from out_ready_i).
- While out_valid_o && !out_ready_i, int_o and flag_o hold stable and no item is lost or duplicated.
- Reset (any time, including mid-operation): both valids become 0, int_o = 0, flag_o = 0, in_ready_o = 1 after reset. In-flight items are discarded.
- in_valid_i while in_ready_o = 0 is ignored; the source must hold it.

## Configuration
- FP2INT_ROUND_EN defined: all four rounding modes are honoured as above.
- FP2INT_ROUND_EN undefined: rnd_mode_i is ignored, RTZ is always used, and rounding-increment logic is removed. flag[2] is still reported.

## Structure
- Shared ibex_pkg holds:
  - the existing Classif_e
  - new fp_rnd_e (RNE/RTZ/RDN/RUP)
  - the flag bit index constants FP2I_INVALID/FP2I_UNDER/FP2I_INEXACT
- One sub-module, fp_classify (parametrised EXP_W/MAN_W), outputs Classif_e and is instantiated in stage 1. It is reusable by other FPU blocks.

## Test plan
- bf16 0x4049 (3.140625), signed, RNE -> 3, flag 100. Same with RUP -> 4, flag 100.
- 0x3FC0 (1.5) RNE -> 2; 0x4020 (2.5) RNE -> 2, RTZ -> 2, RUP -> 3; 0xC020 (-2.5) RDN signed -> 0xFFFFFFFD. All flag 100.
- 0x4F00 (2^31) signed -> 0x7FFFFFFF, flag 001; unsigned -> 0x80000000, flag 000. 0xCF00 (-2^31) signed -> 0x80000000, flag 000.
- 0x7FC0 NaN signed -> 0x7FFFFFFF, unsigned -> 0xFFFFFFFF, flag 001. 0xBF80 (-1.0) unsigned -> 0, flag 001. 0xBE80 (-0.25) unsigned RTZ -> 0, flag 110.
- Streaming 8 back-to-back operands with out_ready_i toggling randomly -> results in order, each N+2 when unstalled, outputs stable during stall, no drops.
- Assert rst_ni low with both stages full -> out_valid_o = 0, int_o = 0, flag_o = 0 immediately. After release, first new operand appears 2 cycles after acceptance.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared FPU types: operand classification, rounding modes and the
// flag bit positions used by the float-to-integer converter.
package ibex_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO    = 3'd0,
    CLS_SUBNORM = 3'd1,
    CLS_NORMAL  = 3'd2,
    CLS_INF     = 3'd3,
    CLS_NAN     = 3'd4
  } Classif_e;

  typedef enum logic [1:0] {
    RND_RNE = 2'b00,
    RND_RTZ = 2'b01,
    RND_RDN = 2'b10,
    RND_RUP = 2'b11
  } fp_rnd_e;

  localparam int FP2I_INVALID = 0;
  localparam int FP2I_UNDER   = 1;
  localparam int FP2I_INEXACT = 2;

endpackage

// File: rtl/fp_classify.sv
// Sign-agnostic operand classifier for any EXP_W/MAN_W floating-point format.
module fp_classify
  import ibex_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic [EXP_W-1:0] i_exp,
  input  logic [MAN_W-1:0] i_man,
  output Classif_e         o_cls
);

  always_comb begin
    if (&i_exp) begin
      o_cls = (|i_man) ? CLS_NAN : CLS_INF;
    end else if (i_exp == '0) begin
      o_cls = (|i_man) ? CLS_SUBNORM : CLS_ZERO;
    end else begin
      o_cls = CLS_NORMAL;
    end
  end

endmodule

// File: rtl/fp_to_int_pipe.sv
// Two-stage float-to-integer converter with saturation and IEEE flags.
// Define FP2INT_ROUND_EN to honour rnd_mode_i; otherwise RTZ is always used.
module fp_to_int_pipe
  import ibex_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int INT_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [EXP_W+MAN_W:0]     fp_i,
  input  logic                     signed_i,
  input  logic [1:0]               rnd_mode_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [INT_W-1:0]         int_o,
  output logic [2:0]               flag_o
);

  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int SHW  = $clog2(INT_W + 2);
  localparam int AW   = INT_W + MAN_W + 1;
  localparam logic [INT_W-1:0] SMAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] SMIN = {1'b1, {(INT_W-1){1'b0}}};

  // Handshake: a stage loads when its successor can take its item, so
  // in_ready_o is combinational from out_ready_i and no item is lost.
  logic r_s1_valid, r_s2_valid;
  logic w_s2_load, w_s1_load;
  assign w_s2_load  = !r_s2_valid || out_ready_i;
  assign in_ready_o = !r_s1_valid || w_s2_load;
  assign w_s1_load  = in_valid_i && in_ready_o;

  Classif_e w_cls;
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify (
    .i_exp (fp_i[MAN_W +: EXP_W]),
    .i_man (fp_i[MAN_W-1:0]),
    .o_cls (w_cls)
  );

  // Shift places the hidden bit at weight 2^E; INT_W+1 means "below one half".
  logic signed [31:0] w_e;
  logic               w_big;
  logic [SHW-1:0]     w_sh;
  always_comb begin
    w_e   = signed'(32'(fp_i[MAN_W +: EXP_W])) - BIAS;
    w_big = (w_e >= INT_W);
    if (w_e <= -2) begin
      w_sh = SHW'(INT_W + 1);
    end else if (w_big) begin
      w_sh = '0;
    end else begin
      w_sh = SHW'(INT_W - 1 - w_e);
    end
  end

  Classif_e       r_s1_cls;
  logic           r_s1_sign, r_s1_big, r_s1_signed;
  logic [SHW-1:0] r_s1_sh;
  logic [MAN_W:0] r_s1_sig;
`ifdef FP2INT_ROUND_EN
  fp_rnd_e        r_s1_mode;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid  <= 1'b0;
      r_s1_cls    <= CLS_ZERO;
      r_s1_sign   <= 1'b0;
      r_s1_big    <= 1'b0;
      r_s1_signed <= 1'b0;
      r_s1_sh     <= '0;
      r_s1_sig    <= '0;
`ifdef FP2INT_ROUND_EN
      r_s1_mode   <= RND_RNE;
`endif
    end else begin
      if (in_ready_o) r_s1_valid <= in_valid_i;
      if (w_s1_load) begin
        r_s1_cls    <= w_cls;
        r_s1_sign   <= fp_i[EXP_W+MAN_W];
        r_s1_big    <= w_big;
        r_s1_signed <= signed_i;
        r_s1_sh     <= w_sh;
        r_s1_sig    <= {1'b1, fp_i[MAN_W-1:0]};
`ifdef FP2INT_ROUND_EN
        r_s1_mode   <= fp_rnd_e'(rnd_mode_i);
`endif
      end
    end
  end

  logic [AW-1:0]    w_aligned;
  logic [INT_W-1:0] w_int_part;
  logic             w_guard, w_sticky, w_inc;
  logic [INT_W:0]   w_mag;
  always_comb begin
    w_aligned = {r_s1_sig, {INT_W{1'b0}}} >> r_s1_sh;
    if (r_s1_sh > SHW'(INT_W)) begin
      w_int_part = '0;
      w_guard    = 1'b0;
      w_sticky   = 1'b1;
    end else begin
      w_int_part = w_aligned[AW-1 -: INT_W];
      w_guard    = w_aligned[MAN_W];
      w_sticky   = |w_aligned[MAN_W-1:0];
    end
  end

`ifdef FP2INT_ROUND_EN
  always_comb begin
    case (r_s1_mode)
      RND_RNE: w_inc = w_guard & (w_sticky | w_int_part[0]);
      RND_RDN: w_inc = r_s1_sign & (w_guard | w_sticky);
      RND_RUP: w_inc = !r_s1_sign & (w_guard | w_sticky);
      default: w_inc = 1'b0;
    endcase
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = ^rnd_mode_i;
  assign w_inc = 1'b0;
`endif

  assign w_mag = {1'b0, w_int_part} + {{INT_W{1'b0}}, w_inc};

  logic [INT_W-1:0] w_res;
  logic [2:0]       w_flag;
  logic             w_ovf_pos, w_ovf_neg;
  always_comb begin
    w_res     = '0;
    w_flag    = '0;
    w_ovf_pos = 1'b0;
    w_ovf_neg = 1'b0;
    case (r_s1_cls)
      CLS_ZERO: w_res = '0;
      CLS_SUBNORM: begin
        w_flag[FP2I_UNDER]   = 1'b1;
        w_flag[FP2I_INEXACT] = 1'b1;
      end
      CLS_NAN: w_ovf_pos = 1'b1;
      CLS_INF: begin
        w_ovf_pos = !r_s1_sign;
        w_ovf_neg = r_s1_sign;
      end
      default: begin
        if (r_s1_big) begin
          w_ovf_pos = !r_s1_sign;
          w_ovf_neg = r_s1_sign;
        end else if (r_s1_signed) begin
          w_ovf_pos = !r_s1_sign && (w_mag > {1'b0, SMAX});
          w_ovf_neg = r_s1_sign && (w_mag > {1'b0, SMIN});
        end else begin
          w_ovf_pos = !r_s1_sign && w_mag[INT_W];
          w_ovf_neg = r_s1_sign && (w_mag != '0);
        end
        w_res = r_s1_sign ? -w_mag[INT_W-1:0] : w_mag[INT_W-1:0];
        w_flag[FP2I_UNDER]   = (w_mag == '0);
        w_flag[FP2I_INEXACT] = w_guard | w_sticky;
      end
    endcase
    // Saturation overrides everything, including inexact.
    if (w_ovf_pos) begin
      w_res  = r_s1_signed ? SMAX : '1;
      w_flag = 3'b001;
    end else if (w_ovf_neg) begin
      w_res  = r_s1_signed ? SMIN : '0;
      w_flag = 3'b001;
    end
  end

  logic [INT_W-1:0] r_int;
  logic [2:0]       r_flag;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_valid <= 1'b0;
      r_int      <= '0;
      r_flag     <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_int  <= w_res;
        r_flag <= w_flag;
      end
    end
  end

  assign out_valid_o = r_s2_valid;
  assign int_o       = r_int;
  assign flag_o      = r_flag;

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Bench for fp_to_int_pipe (bf16 -> int32): vector table, scoreboard,
// backpressure streaming and mid-flight reset.
module tb_fp_to_int_pipe;

  localparam int W  = 35;
  localparam int NV = 28;
`ifdef FP2INT_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] fp = '0;
  logic        sgn = 1'b0;
  logic [1:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] int_o;
  logic [2:0]  flag_o;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_mode = 0;
  bit lat_en = 1'b1;
  logic [W-1:0] exp_q[$];
  int acc_q[$];
  bit stall_active = 1'b0;
  logic [31:0] held_int;
  logic [2:0]  held_flag;

  typedef struct {
    logic [15:0] fp;
    logic        sgn;
    logic [1:0]  mode;
    logic [31:0] e_rnd;
    logic [31:0] e_rtz;
    logic [2:0]  flag;
  } vec_t;
  vec_t vecs[NV];

  fp_to_int_pipe #(.EXP_W(8), .MAN_W(7), .INT_W(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .fp_i        (fp),
    .signed_i    (sgn),
    .rnd_mode_i  (mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .int_o       (int_o),
    .flag_o      (flag_o)
  );

  // Clock / reset / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Consumer readiness: 0 always ready, 1 random, 2 stalled
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard / monitor
  initial begin
    logic [W-1:0] e;
    int a;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_ni) begin
        stall_active = 1'b0;
      end else begin
        if (stall_active) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_int", int_o, held_int);
          chk("stall_flag", 32'(flag_o), 32'(held_flag));
        end
        stall_active = 1'b0;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_output: got 0x%08h with nothing pending", int_o);
          end else if (out_ready) begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            chk("result_int", int_o, e[34:3]);
            chk("result_flag", 32'(flag_o), 32'(e[2:0]));
            if (lat_en) chk("latency", 32'(cyc - a), 32'd2);
          end else begin
            stall_active = 1'b1;
            held_int = int_o;
            held_flag = flag_o;
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic send(input int i);
    int n = 0;
    @(negedge clk);
    fp = vecs[i].fp;
    sgn = vecs[i].sgn;
    mode = vecs[i].mode;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: vector %0d not accepted, in_ready=%0b", i, in_ready);
    end else begin
      exp_q.push_back({(ROUND_EN ? vecs[i].e_rnd : vecs[i].e_rtz), vecs[i].flag});
      acc_q.push_back(cyc);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    //            fp       sgn   mode   rounded        rtz            flag
    vecs[0]  = '{16'h4049, 1'b1, 2'b00, 32'd3,         32'd3,         3'b100};
    vecs[1]  = '{16'h4049, 1'b1, 2'b11, 32'd4,         32'd3,         3'b100};
    vecs[2]  = '{16'h3FC0, 1'b1, 2'b00, 32'd2,         32'd1,         3'b100};
    vecs[3]  = '{16'h4020, 1'b1, 2'b00, 32'd2,         32'd2,         3'b100};
    vecs[4]  = '{16'h4020, 1'b1, 2'b01, 32'd2,         32'd2,         3'b100};
    vecs[5]  = '{16'h4020, 1'b1, 2'b11, 32'd3,         32'd2,         3'b100};
    vecs[6]  = '{16'hC020, 1'b1, 2'b10, 32'hFFFFFFFD,  32'hFFFFFFFE,  3'b100};
    vecs[7]  = '{16'h4F00, 1'b1, 2'b00, 32'h7FFFFFFF,  32'h7FFFFFFF,  3'b001};
    vecs[8]  = '{16'h4F00, 1'b0, 2'b00, 32'h80000000,  32'h80000000,  3'b000};
    vecs[9]  = '{16'hCF00, 1'b1, 2'b00, 32'h80000000,  32'h80000000,  3'b000};
    vecs[10] = '{16'h7FC0, 1'b1, 2'b00, 32'h7FFFFFFF,  32'h7FFFFFFF,  3'b001};
    vecs[11] = '{16'h7FC0, 1'b0, 2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  3'b001};
    vecs[12] = '{16'hBF80, 1'b0, 2'b00, 32'd0,         32'd0,         3'b001};
    vecs[13] = '{16'hBE80, 1'b0, 2'b01, 32'd0,         32'd0,         3'b110};
    vecs[14] = '{16'h0000, 1'b1, 2'b00, 32'd0,         32'd0,         3'b000};
    vecs[15] = '{16'h8000, 1'b0, 2'b11, 32'd0,         32'd0,         3'b000};
    vecs[16] = '{16'h7F80, 1'b0, 2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  3'b001};
    vecs[17] = '{16'hFF80, 1'b1, 2'b00, 32'h80000000,  32'h80000000,  3'b001};
    vecs[18] = '{16'h5F80, 1'b1, 2'b00, 32'h7FFFFFFF,  32'h7FFFFFFF,  3'b001};
    vecs[19] = '{16'h42FE, 1'b1, 2'b00, 32'd127,       32'd127,       3'b000};
    vecs[20] = '{16'h3F00, 1'b1, 2'b00, 32'd0,         32'd0,         3'b110};
    vecs[21] = '{16'hC040, 1'b1, 2'b00, 32'hFFFFFFFD,  32'hFFFFFFFD,  3'b000};
    vecs[22] = '{16'h4F80, 1'b0, 2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  3'b001};
    vecs[23] = '{16'h4F7F, 1'b0, 2'b00, 32'hFF000000,  32'hFF000000,  3'b000};
    vecs[24] = '{16'hBFC0, 1'b0, 2'b10, 32'd0,         32'd0,         3'b001};
    vecs[25] = '{16'h3E80, 1'b1, 2'b10, 32'd0,         32'd0,         3'b110};
    vecs[26] = '{16'hCF00, 1'b0, 2'b01, 32'd0,         32'd0,         3'b001};
    vecs[27] = '{16'hFF80, 1'b0, 2'b00, 32'd0,         32'd0,         3'b001};

    // Reset state
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_int", int_o, 32'd0);
    chk("rst_flag", 32'(flag_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_ni = 1'b1;

    // Table, unstalled, back-to-back
    ready_mode = 0;
    lat_en = 1'b1;
    for (int i = 0; i < NV; i++) send(i);
    idle();
    drain();

    // Streaming with random backpressure
    ready_mode = 1;
    lat_en = 1'b0;
    for (int i = 0; i < 8; i++) send(i);
    idle();
    drain();

    // Fill both stages under a stall, then reset mid-flight
    ready_mode = 2;
    send(7);
    send(10);
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_int", int_o, 32'd0);
    chk("midrst_flag", 32'(flag_o), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    ready_mode = 0;
    lat_en = 1'b1;
    send(6);
    send(23);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
